demux4_lane_router: RTL and testbench
=====================================

Name: demux4_lane_router

Overview:
- Sequential 1-to-4 demultiplexer that distributes one incoming sample stream (price ticks) to four downstream lanes, for example four parallel SMA engines.
- Performs the inverse of the team's 4:1 select muxing: one source feeds four destinations.
- Each lane has a one-entry registered holding stage with valid/ready handshake.
- Destination comes either from an explicit select or from an internal round-robin pointer.

Parameters:
- DATA_WIDTH, 16, width of each sample word.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all lane holding registers.
- rr_mode  input  1  1 = round-robin destination; 0 = destination from in_sel.
- in_data  input  DATA_WIDTH  incoming sample.
- in_sel  input  2  explicit destination lane; used only when rr_mode=0.
- in_valid  input  1  in_data/in_sel are valid.
- in_ready  output  1  router accepts the current input this cycle.
- out_data  output  4*DATA_WIDTH  lane i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  4  lane i holding register is full.
- out_ready  input  4  lane i consumer accepts this cycle.

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock, and reset_n clears state immediately without waiting for an edge. On reset: every lane empty, out_valid=0, out_data=0, rr_ptr=0.
- dest = rr_mode ? rr_ptr : in_sel.
- in_ready is combinational: !flush && (!full[dest] || out_ready[dest]).
- Accept occurs when in_valid && in_ready. On accept, the lane[dest] register loads in_data and full[dest] is set at the next edge. Latency from input to out_valid is 1 cycle.
- Drain: out_valid[i] && out_ready[i] clears full[i] at the edge, unless the same lane is loaded in that cycle, in which case it stays full with the new data.
- Lanes are independent. A stalled lane blocks input only when dest selects that lane (head-of-line blocking; no reordering).
- Round-robin pointer:
  - rr_ptr advances 0→1→2→3→0 on each accept while rr_mode=1.
  - It does not advance on a stall, while rr_mode=0, or during flush.
  - When rr_mode toggles, rr_ptr holds its value.
- Flush:
  - At the edge, clears all full bits and lane data to 0 and sets rr_ptr=0.
  - in_ready=0 while flush=1, so no input is accepted that cycle.
  - Flush has priority over simultaneous drain and load.
- out_data of an empty lane retains its last value (0 after reset or flush). Consumers must qualify data with out_valid.
- Per-lane data order equals arrival order.
- Reset asserted mid-transfer discards all held samples. No partial state survives.
- Outputs out_valid and out_data are registered. in_ready is the only combinational output.

Optional Feature:
- Macro DEMUX4_LANE_COUNT_EN.
- Defined: adds output lane_count, width 32 (4×8 bits), lane i at [i*8 +: 8].
  - Each counter increments by one per accept into lane i and wraps 255→0.
  - Counters clear on reset_n and on flush.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: reset_n=0 → out_valid=4'b0000, out_data=0, in_ready=1.
- Explicit routing: rr_mode=0, all out_ready=0; send 0x0011 sel=2 → next cycle out_valid=4'b0100, lane2=0x0011. Then send sel=2 again → in_ready=0 and the input is held. Assert out_ready[2] → both the drain and the load happen in the same cycle, and lane2=new data.
- Round-robin wrap: rr_mode=1, out_ready=4'b1111; send 0xA0..0xA4 back-to-back → lanes receive 0xA0,0xA1,0xA2,0xA3 in order 0,1,2,3, then 0xA4 goes to lane0; in_ready stays 1 throughout.
- RR stall: rr_mode=1, lane1 full with out_ready[1]=0 and rr_ptr=1 → in_ready=0 and rr_ptr stays at 1. Release out_ready[1] → accept proceeds to lane1 and rr_ptr becomes 2.
- Flush with simultaneous input: lanes 0 and 3 full, flush=1 with in_valid=1 → in_ready=0, next cycle out_valid=0 and rr_ptr=0. With DEMUX4_LANE_COUNT_EN defined, lane_count=0.
- Counter wrap (DEMUX4_LANE_COUNT_EN): 256 accepts into lane1 → lane_count[15:8]=0x00. The 257th accept gives 0x01, and the other lanes read 0.

Source files
------------

// File: rtl/demux4_lane_router.sv
`default_nettype none
// ============================================================================
// Module      : demux4_lane_router
// Description : 1-to-4 sample router with one-entry valid/ready holding stage
//               per lane. Destination is explicit (in_sel) or round-robin.
//               Optional per-lane accept counters: DEMUX4_LANE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demux4_lane_router #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    rr_mode,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [1:0]              in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*DATA_WIDTH-1:0] out_data,
  output logic [3:0]              out_valid,
  input  logic [3:0]              out_ready
`ifdef DEMUX4_LANE_COUNT_EN
  ,
  output logic [31:0]             lane_count
`endif
);

  localparam int NUM_LANES = 4;

  logic [1:0] dest;
  logic       accept;
  logic [3:0] load;
  logic [3:0] drain;
  logic [3:0] full_q;
  logic [3:0] full_d;
  logic [1:0] rr_ptr_q;
  logic [1:0] rr_ptr_d;

  // A full lane still accepts when it is draining in the same cycle.
  always_comb begin
    dest     = rr_mode ? rr_ptr_q : in_sel;
    in_ready = !flush && (!full_q[dest] || out_ready[dest]);
    accept   = in_valid && in_ready;
    load     = accept ? (4'b0001 << dest) : 4'b0000;
    drain    = full_q & out_ready;
  end

  always_comb begin
    full_d   = full_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      full_d   = 4'b0000;
      rr_ptr_d = 2'd0;
    end else begin
      full_d = (full_q & ~drain) | load;
      if (accept && rr_mode) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q   <= 4'b0000;
      rr_ptr_q <= 2'd0;
    end else begin
      full_q   <= full_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = full_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    // Data is held while empty; consumers qualify with out_valid.
    always_comb begin
      data_d = data_q;
      if (flush) begin
        data_d = '0;
      end else if (load[i]) begin
        data_d = in_data;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
  end

`ifdef DEMUX4_LANE_COUNT_EN
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_count
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
        cnt_d = 8'd0;
      end else if (load[i]) begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= 8'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign lane_count[i*8 +: 8] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux4_lane_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux4_lane_router
// Description : Self-checking bench for demux4_lane_router with a per-lane
//               reference model driven by directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4_lane_router;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          rr_mode;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
`ifdef DEMUX4_LANE_COUNT_EN
  logic [31:0]   lane_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lane occupancy, lane contents, pointer, accept counts.
  bit [3:0]      m_full;
  logic [DW-1:0] m_data [4];
  int            m_ptr;
  int            m_cnt [4];

  always #5 clk = ~clk;

  demux4_lane_router #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .rr_mode   (rr_mode),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX4_LANE_COUNT_EN
    ,
    .lane_count(lane_count)
`endif
  );

  function automatic logic [4*DW-1:0] m_data_vec();
    logic [4*DW-1:0] v;
    for (int i = 0; i < 4; i++) v[i*DW +: DW] = m_data[i];
    return v;
  endfunction

  function automatic logic [31:0] m_cnt_vec();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(m_cnt[i]);
    return v;
  endfunction

  function automatic int m_dest();
    return rr_mode ? m_ptr : int'(in_sel);
  endfunction

  function automatic bit m_ready();
    int d;
    d = m_dest();
    return !flush && (!m_full[d] || out_ready[d]);
  endfunction

  task automatic m_clear();
    m_full = 4'b0000;
    m_ptr  = 0;
    for (int i = 0; i < 4; i++) begin
      m_data[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit rdy;
    int d;
    rdy = m_ready();
    d   = m_dest();
    @(posedge clk);
    if (flush) begin
      m_clear();
    end else begin
      for (int i = 0; i < 4; i++)
        if (m_full[i] && out_ready[i]) m_full[i] = 1'b0;
      if (in_valid && rdy) begin
        m_full[d] = 1'b1;
        m_data[d] = in_data;
        m_cnt[d]  = (m_cnt[d] + 1) % 256;
        if (rr_mode) m_ptr = (m_ptr + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b0;
    tick();
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b1;
    flush     = 1'b0;
    rr_mode   = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #2 reset_n = 1'b0;
    #1;
    m_clear();
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
`ifdef DEMUX4_LANE_COUNT_EN
    n_cmp++; if (lane_count !== 32'h0) begin n_bad++; $display("FAIL reset_count: got %h want 0", lane_count); end
`endif
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_idle_valid: got %b want 0000", out_valid); end
  endtask

  task automatic test_explicit();
    rr_mode = 1'b0; out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 16'h0011;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL expl_ready0: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 4'b0100) begin n_bad++; $display("FAIL expl_valid1: got %b want 0100", out_valid); end
    n_cmp++; if (out_data[2*DW +: DW] !== 16'h0011) begin n_bad++; $display("FAIL expl_lane2a: got %h want 0011", out_data[2*DW +: DW]); end
    in_data = 16'h0022;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL expl_block: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (out_data[2*DW +: DW] !== 16'h0011) begin n_bad++; $display("FAIL expl_hold: got %h want 0011", out_data[2*DW +: DW]); end
    out_ready = 4'b0100;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL expl_ready_drain: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 4'b0100) begin n_bad++; $display("FAIL expl_valid2: got %b want 0100", out_valid); end
    n_cmp++; if (out_data[2*DW +: DW] !== 16'h0022) begin n_bad++; $display("FAIL expl_lane2b: got %h want 0022", out_data[2*DW +: DW]); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL expl_drained: got %b want 0000", out_valid); end
    out_ready = 4'b0000;
  endtask

  task automatic test_rr_wrap();
    do_flush();
    rr_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 16'h00A0 + DW'(k);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rr_ready k=%0d: got %b want 1", k, in_ready); end
      tick();
      n_cmp++; if (out_valid[k%4] !== 1'b1) begin n_bad++; $display("FAIL rr_valid k=%0d: got %b want lane %0d set", k, out_valid, k%4); end
      n_cmp++; if (out_data[(k%4)*DW +: DW] !== 16'h00A0 + DW'(k)) begin n_bad++; $display("FAIL rr_data k=%0d: got %h want %h", k, out_data[(k%4)*DW +: DW], 16'h00A0 + DW'(k)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rr_stall();
    do_flush();
    rr_mode = 1'b0; out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h00C1;
    tick();
    rr_mode = 1'b1; in_data = 16'h00B0;
    tick();
    n_cmp++; if (out_valid !== 4'b0011) begin n_bad++; $display("FAIL stall_setup: got %b want 0011", out_valid); end
    in_data = 16'h00B1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    tick();
    tick();
    n_cmp++; if (out_data[1*DW +: DW] !== 16'h00C1) begin n_bad++; $display("FAIL stall_hold: got %h want 00c1", out_data[1*DW +: DW]); end
    out_ready = 4'b0010;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_data[1*DW +: DW] !== 16'h00B1) begin n_bad++; $display("FAIL stall_lane1: got %h want 00b1", out_data[1*DW +: DW]); end
    out_ready = 4'b0000; in_data = 16'h00B2;
    tick();
    n_cmp++; if (out_valid !== 4'b0111) begin n_bad++; $display("FAIL stall_ptr2_valid: got %b want 0111", out_valid); end
    n_cmp++; if (out_data[2*DW +: DW] !== 16'h00B2) begin n_bad++; $display("FAIL stall_ptr2_data: got %h want 00b2", out_data[2*DW +: DW]); end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_flush();
    rr_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 16'h00DD;
    tick();
    in_valid = 1'b0;
    tick();
    rr_mode = 1'b0; out_ready = 4'b0000; in_valid = 1'b1;
    in_sel = 2'd0; in_data = 16'h00D0; tick();
    in_sel = 2'd3; in_data = 16'h00D3; tick();
    n_cmp++; if (out_valid !== 4'b1001) begin n_bad++; $display("FAIL flush_setup: got %b want 1001", out_valid); end
    flush = 1'b1; in_sel = 2'd1; in_data = 16'h00EE;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL flush_valid: got %b want 0000", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL flush_data: got %h want 0", out_data); end
`ifdef DEMUX4_LANE_COUNT_EN
    n_cmp++; if (lane_count !== 32'h0) begin n_bad++; $display("FAIL flush_count: got %h want 0", lane_count); end
`endif
    rr_mode = 1'b1; in_valid = 1'b1; in_data = 16'h00E0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 4'b0001) begin n_bad++; $display("FAIL flush_ptr0: got %b want 0001", out_valid); end
    n_cmp++; if (out_data[0 +: DW] !== 16'h00E0) begin n_bad++; $display("FAIL flush_ptr0_data: got %h want 00e0", out_data[0 +: DW]); end
  endtask

`ifdef DEMUX4_LANE_COUNT_EN
  task automatic test_counter_wrap();
    do_flush();
    rr_mode = 1'b0; in_sel = 2'd1; out_ready = 4'b0010; in_valid = 1'b1;
    repeat (256) begin
      in_data = DW'($urandom);
      tick();
    end
    n_cmp++; if (lane_count[15:8] !== 8'h00) begin n_bad++; $display("FAIL cnt_wrap256: got %h want 00", lane_count[15:8]); end
    n_cmp++; if (lane_count !== m_cnt_vec()) begin n_bad++; $display("FAIL cnt_model256: got %h want %h", lane_count, m_cnt_vec()); end
    tick();
    n_cmp++; if (lane_count[15:8] !== 8'h01) begin n_bad++; $display("FAIL cnt_257: got %h want 01", lane_count[15:8]); end
    n_cmp++; if ({lane_count[31:16], lane_count[7:0]} !== 24'h0) begin n_bad++; $display("FAIL cnt_others: got %h want 0", lane_count); end
    in_valid = 1'b0; out_ready = 4'b0000;
    tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush     = ($urandom_range(15) == 0);
      if ($urandom_range(7) == 0) rr_mode = ~rr_mode;
      in_valid  = ($urandom_range(3) != 0);
      in_sel    = 2'($urandom_range(3));
      in_data   = DW'($urandom);
      out_ready = 4'($urandom);
      #1;
      n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, m_ready()); end
      tick();
      n_cmp++; if (out_valid !== m_full) begin n_bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, m_full); end
      n_cmp++; if (out_data !== m_data_vec()) begin n_bad++; $display("FAIL rand_data c=%0d: got %h want %h", c, out_data, m_data_vec()); end
`ifdef DEMUX4_LANE_COUNT_EN
      n_cmp++; if (lane_count !== m_cnt_vec()) begin n_bad++; $display("FAIL rand_count c=%0d: got %h want %h", c, lane_count, m_cnt_vec()); end
`endif
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    rr_mode = 1'b0; out_ready = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel  = 2'(i);
      in_data = 16'h00F0 + DW'(i);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 4'b1111) begin n_bad++; $display("FAIL rmid_setup: got %b want 1111", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    m_clear();
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL rmid_valid: got %b want 0000", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rmid_data: got %h want 0", out_data); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL rmid_after: got %b want 0000", out_valid); end
  endtask

  initial begin
    test_reset();
    test_explicit();
    test_rr_wrap();
    test_rr_stall();
    test_flush();
`ifdef DEMUX4_LANE_COUNT_EN
    test_counter_wrap();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
